// File: rtl/branch_feedback_tracker_if.sv
// Predictor-side bundle of the branch feedback tracker.
// The request leg (valid/pc/target out, prediction back) is combinational.
// The feedback leg carries one registered resolution record per pulse.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface branch_feedback_tracker_if #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic [ADDR_WIDTH-1:0] req_target;
    logic                  req_prediction;
    logic                  fb_valid;
    logic [ADDR_WIDTH-1:0] fb_pc;
    logic                  fb_prediction;
    logic                  fb_outcome;

    // Tracker side: issues requests and feedback, receives the prediction.
    modport master (
        output req_valid, req_pc, req_target,
        input  req_prediction,
        output fb_valid, fb_pc, fb_prediction, fb_outcome
    );

    // Predictor side.
    modport slave (
        input  req_valid, req_pc, req_target,
        output req_prediction,
        input  fb_valid, fb_pc, fb_prediction, fb_outcome
    );
endinterface

// File: rtl/branch_feedback_tracker.sv
// branch_feedback_tracker: in-order queue of in-flight conditional branches.
// Decode requests a prediction through the tracker; the {pc, prediction} pair
// is queued. When EX resolves the oldest branch, the head is popped, checked
// against the resolving PC, and turned into a one-cycle feedback record for
// the predictor. A mispredict squashes every younger (wrong-path) entry.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
} BranchOutcome;

module branch_feedback_tracker #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // decode side
    input  logic                       i_dec_valid,
    input  logic [ADDR_WIDTH-1:0]      i_dec_pc,
    input  logic [ADDR_WIDTH-1:0]      i_dec_target,
    output logic                       o_dec_ready,
    output BranchOutcome               o_dec_prediction,
    // predictor request/feedback bundle
    branch_feedback_tracker_if.master  bus,
    // execute side
    input  logic                       i_ex_valid,
    input  logic [ADDR_WIDTH-1:0]      i_ex_pc,
    input  BranchOutcome               i_ex_outcome,
    input  logic                       i_flush,
    // status
    output logic                       o_mispredict,
    output logic                       o_pc_mismatch,
    output logic                       o_underflow,
    output logic [CW-1:0]              o_count,
    output logic [31:0]                o_stat_branches,
    output logic [31:0]                o_stat_mispredicts
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // queue storage and pointers
    logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
    BranchOutcome          r_pred_mem [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    // registered feedback and status
    logic                  r_fb_valid;
    logic [ADDR_WIDTH-1:0] r_fb_pc;
    BranchOutcome          r_fb_prediction;
    BranchOutcome          r_fb_outcome;
    logic                  r_mispredict;
    logic                  r_pc_mismatch;
    logic                  r_underflow;
    logic [31:0]           r_stat_branches;
    logic [31:0]           r_stat_mispredicts;

    // per-cycle decisions
    logic                  w_dec_ready;
    logic                  w_push;
    logic                  w_resolve;
    logic                  w_empty_resolve;
    logic                  w_pc_match;
    logic                  w_mispred;
    logic                  w_clear;
    logic [ADDR_WIDTH-1:0] w_head_pc;
    BranchOutcome          w_head_pred;
    BranchOutcome          w_req_prediction;

    assign w_req_prediction = BranchOutcome'(bus.req_prediction);
    assign w_head_pc        = r_pc_mem[r_head];
    assign w_head_pred      = r_pred_mem[r_head];

    // A flushing cycle never accepts, so a dropped push is never acknowledged.
    assign w_dec_ready      = (r_count != CNT_FULL) & ~i_flush;
    assign w_push           = i_dec_valid & w_dec_ready;
    // Resolve sees only the pre-edge occupancy: no bypass of a same-cycle push.
    assign w_resolve        = i_ex_valid & (r_count != CNT_ZERO);
    assign w_empty_resolve  = i_ex_valid & (r_count == CNT_ZERO);
    assign w_pc_match       = w_resolve & (i_ex_pc == w_head_pc);
    assign w_mispred        = w_pc_match & (w_head_pred != i_ex_outcome);
    // Everything behind a mispredicted branch is wrong-path.
    assign w_clear          = i_flush | w_mispred;

    // Head/tail pointers and occupancy; a clear overrides any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= PTR_ZERO;
            r_tail  <= PTR_ZERO;
            r_count <= CNT_ZERO;
        end else if (w_clear) begin
            r_head  <= PTR_ZERO;
            r_tail  <= PTR_ZERO;
            r_count <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_resolve) begin
                r_head <= r_head + PTR_ONE;
            end
            case ({w_push, w_resolve})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: record the PC and the prediction handed to decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= {ADDR_WIDTH{1'b0}};
                r_pred_mem[i] <= NOT_TAKEN;
            end
        end else if (w_push) begin
            r_pc_mem[r_tail]   <= i_dec_pc;
            r_pred_mem[r_tail] <= w_req_prediction;
        end
    end

    // Feedback record, error flags and wrap-around statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fb_valid         <= 1'b0;
            r_fb_pc            <= {ADDR_WIDTH{1'b0}};
            r_fb_prediction    <= NOT_TAKEN;
            r_fb_outcome       <= NOT_TAKEN;
            r_mispredict       <= 1'b0;
            r_pc_mismatch      <= 1'b0;
            r_underflow        <= 1'b0;
            r_stat_branches    <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            r_fb_valid    <= w_pc_match;
            r_mispredict  <= w_mispred;
            r_pc_mismatch <= w_resolve & ~w_pc_match;
            if (w_pc_match) begin
                r_fb_pc         <= w_head_pc;
                r_fb_prediction <= w_head_pred;
                r_fb_outcome    <= i_ex_outcome;
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (w_mispred) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
            if (w_empty_resolve) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_dec_ready        = w_dec_ready;
    assign o_dec_prediction   = w_req_prediction;
    assign bus.req_valid      = w_push;
    assign bus.req_pc         = i_dec_pc;
    assign bus.req_target     = i_dec_target;
    assign bus.fb_valid       = r_fb_valid;
    assign bus.fb_pc          = r_fb_pc;
    assign bus.fb_prediction  = r_fb_prediction;
    assign bus.fb_outcome     = r_fb_outcome;
    assign o_mispredict       = r_mispredict;
    assign o_pc_mismatch      = r_pc_mismatch;
    assign o_underflow        = r_underflow;
    assign o_count            = r_count;
    assign o_stat_branches    = r_stat_branches;
    assign o_stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_branch_feedback_tracker.sv
// Bench for branch_feedback_tracker: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the tracker's rules.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_feedback_tracker;
    localparam int DEPTH = 8;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dec_valid;
    logic [AW-1:0] dec_pc;
    logic [AW-1:0] dec_target;
    logic          req_pred;
    logic          ex_valid;
    logic [AW-1:0] ex_pc;
    BranchOutcome  ex_outcome;
    logic          flush;

    logic          dec_ready;
    BranchOutcome  dec_prediction;
    logic          mispredict;
    logic          pc_mismatch;
    logic          underflow;
    logic [3:0]    count;
    logic [31:0]   stat_b;
    logic [31:0]   stat_m;

    branch_feedback_tracker_if #(.ADDR_WIDTH(AW)) bfi ();

    branch_feedback_tracker #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_dec_valid        (dec_valid),
        .i_dec_pc           (dec_pc),
        .i_dec_target       (dec_target),
        .o_dec_ready        (dec_ready),
        .o_dec_prediction   (dec_prediction),
        .bus                (bfi.master),
        .i_ex_valid         (ex_valid),
        .i_ex_pc            (ex_pc),
        .i_ex_outcome       (ex_outcome),
        .i_flush            (flush),
        .o_mispredict       (mispredict),
        .o_pc_mismatch      (pc_mismatch),
        .o_underflow        (underflow),
        .o_count            (count),
        .o_stat_branches    (stat_b),
        .o_stat_mispredicts (stat_m)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [AW-1:0] pc;
        logic          pred;
    } ent_t;

    ent_t          mq[$];
    logic          m_fb_valid, m_fb_pred, m_fb_out, m_mis, m_pcm, m_unf;
    logic [AW-1:0] m_fb_pc;
    logic [31:0]   m_sb, m_sm;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        mq.delete();
        m_fb_valid = 1'b0; m_fb_pc = '0; m_fb_pred = 1'b0; m_fb_out = 1'b0;
        m_mis = 1'b0; m_pcm = 1'b0; m_unf = 1'b0; m_sb = 32'd0; m_sm = 32'd0;
    endtask

    // One clock edge of the tracker's rules, applied to the queue.
    task automatic model_step();
        bit   ready, push, clr;
        ent_t h;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ready = (mq.size() != DEPTH) && !flush;
        push  = dec_valid && ready;
        clr   = flush;
        m_fb_valid = 1'b0; m_mis = 1'b0; m_pcm = 1'b0;
        if (ex_valid) begin
            if (mq.size() == 0) m_unf = 1'b1;
            else begin
                h = mq.pop_front();
                if (h.pc == ex_pc) begin
                    m_fb_valid = 1'b1; m_fb_pc = h.pc; m_fb_pred = h.pred; m_fb_out = ex_outcome;
                    m_sb = m_sb + 32'd1;
                    if (h.pred != ex_outcome) begin
                        m_mis = 1'b1; m_sm = m_sm + 32'd1; clr = 1'b1;
                    end
                end else m_pcm = 1'b1;
            end
        end
        if (push) mq.push_back(ent_t'{pc: dec_pc, pred: req_pred});
        if (clr) mq.delete();
    endtask

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        bit exp_ready;
        if (chk_en) begin
            exp_ready = (mq.size() != DEPTH) && !flush;
            chk("dec_ready",      {63'd0, dec_ready}, {63'd0, exp_ready});
            chk("req_valid",      {63'd0, bfi.req_valid}, {63'd0, dec_valid & exp_ready});
            chk("req_pc",         64'(bfi.req_pc), 64'(dec_pc));
            chk("req_target",     64'(bfi.req_target), 64'(dec_target));
            chk("dec_prediction", 64'(dec_prediction), {63'd0, req_pred});
            chk("fb_valid",       {63'd0, bfi.fb_valid}, {63'd0, m_fb_valid});
            chk("fb_pc",          64'(bfi.fb_pc), 64'(m_fb_pc));
            chk("fb_prediction",  {63'd0, bfi.fb_prediction}, {63'd0, m_fb_pred});
            chk("fb_outcome",     {63'd0, bfi.fb_outcome}, {63'd0, m_fb_out});
            chk("mispredict",     {63'd0, mispredict}, {63'd0, m_mis});
            chk("pc_mismatch",    {63'd0, pc_mismatch}, {63'd0, m_pcm});
            chk("underflow",      {63'd0, underflow}, {63'd0, m_unf});
            chk("count",          64'(count), 64'(mq.size()));
            chk("stat_branches",  64'(stat_b), 64'(m_sb));
            chk("stat_mispred",   64'(stat_m), 64'(m_sm));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic dv, input logic [AW-1:0] pc, input logic pr,
                         input logic ev, input logic [AW-1:0] epc, input logic eo,
                         input logic fl);
        dec_valid          = dv;
        dec_pc             = pc;
        dec_target         = pc ^ 32'h0000_8000;
        req_pred           = pr;
        bfi.req_prediction = pr;
        ex_valid           = ev;
        ex_pc              = epc;
        ex_outcome         = BranchOutcome'(eo);
        flush              = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic pr);
        drive(1'b1, pc, pr, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic resolve(input logic [AW-1:0] pc, input logic eo);
        drive(1'b0, 32'h0, 1'b0, 1'b1, pc, eo, 1'b0);
        tick();
    endtask

    initial begin
        logic [AW-1:0] pc_r, epc_r;
        logic          dv_r, pr_r, ev_r, eo_r, fl_r;

        rst_n = 1'b1;
        idle();
        model_reset();
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_count",     64'(count), 64'd0);
        chk("rst_dec_ready", {63'd0, dec_ready}, 64'd1);
        chk("rst_fb_valid",  {63'd0, bfi.fb_valid}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill and drain
        for (int i = 0; i < 8; i++) push(32'h100 + 32'(4 * i), 1'b1);
        chk("full_ready", {63'd0, dec_ready}, 64'd0);
        drive(1'b1, 32'h120, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 chk("full_req_valid", {63'd0, bfi.req_valid}, 64'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            resolve(32'h100 + 32'(4 * i), 1'b1);
            chk("drain_fb_valid", {63'd0, bfi.fb_valid}, 64'd1);
            chk("drain_fb_pc",    64'(bfi.fb_pc), 64'(32'h100 + 32'(4 * i)));
        end
        chk("drain_stat_b", 64'(stat_b), 64'd8);
        chk("drain_count",  64'(count), 64'd0);
        idle(); tick();

        // Mispredict squash
        push(32'h200, 1'b0); push(32'h204, 1'b0); push(32'h208, 1'b0);
        resolve(32'h200, 1'b1);
        chk("mp_fb_pc",   64'(bfi.fb_pc), 64'h200);
        chk("mp_fb_pred", {63'd0, bfi.fb_prediction}, 64'd0);
        chk("mp_fb_out",  {63'd0, bfi.fb_outcome}, 64'd1);
        chk("mp_flag",    {63'd0, mispredict}, 64'd1);
        chk("mp_count",   64'(count), 64'd0);
        chk("mp_stat_m",  64'(stat_m), 64'd1);
        idle(); tick();

        // Wrap-around
        for (int i = 0; i < 5; i++) push(32'h500 + 32'(4 * i), 1'(i));
        for (int i = 0; i < 5; i++) begin
            resolve(32'h500 + 32'(4 * i), 1'(i));
            chk("wrap1_fb_pc", 64'(bfi.fb_pc), 64'(32'h500 + 32'(4 * i)));
        end
        for (int i = 0; i < 6; i++) push(32'h600 + 32'(4 * i), 1'(i));
        for (int i = 0; i < 6; i++) begin
            resolve(32'h600 + 32'(4 * i), 1'(i));
            chk("wrap2_fb_pc",  64'(bfi.fb_pc), 64'(32'h600 + 32'(4 * i)));
            chk("wrap2_fb_out", {63'd0, bfi.fb_outcome}, 64'(i % 2));
        end
        idle(); tick();

        // Flush with simultaneous push and resolve
        push(32'h2F0, 1'b1); push(32'h2F4, 1'b1); push(32'h2F8, 1'b1);
        drive(1'b1, 32'h300, 1'b1, 1'b1, 32'h2F0, 1'b1, 1'b1);
        #1 chk("fl_req_valid", {63'd0, bfi.req_valid}, 64'd0);
        tick();
        chk("fl_fb_valid", {63'd0, bfi.fb_valid}, 64'd1);
        chk("fl_fb_pc",    64'(bfi.fb_pc), 64'h2F0);
        chk("fl_count",    64'(count), 64'd0);
        idle(); tick();
        chk("fl_fb_hold",  64'(bfi.fb_pc), 64'h2F0);

        // Errors: underflow and PC mismatch
        resolve(32'h0, 1'b0);
        chk("uf_set",      {63'd0, underflow}, 64'd1);
        idle(); tick();
        chk("uf_sticky",   {63'd0, underflow}, 64'd1);
        push(32'h400, 1'b1); push(32'h408, 1'b1);
        resolve(32'h404, 1'b1);
        chk("pcm_pulse",   {63'd0, pc_mismatch}, 64'd1);
        chk("pcm_no_fb",   {63'd0, bfi.fb_valid}, 64'd0);
        chk("pcm_count",   64'(count), 64'd1);
        idle(); tick();
        chk("pcm_cleared", {63'd0, pc_mismatch}, 64'd0);

        // Async reset mid-stream with a feedback pending
        push(32'h410, 1'b1); push(32'h414, 1'b1); push(32'h418, 1'b1);
        chk("pre_rst_count", 64'(count), 64'd4);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h408, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_fb_valid",  {63'd0, bfi.fb_valid}, 64'd0);
        chk("ar_fb_pc",     64'(bfi.fb_pc), 64'd0);
        chk("ar_count",     64'(count), 64'd0);
        chk("ar_underflow", {63'd0, underflow}, 64'd0);
        chk("ar_stat_b",    64'(stat_b), 64'd0);
        chk("ar_dec_ready", {63'd0, dec_ready}, 64'd1);
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_fb_valid", {63'd0, bfi.fb_valid}, 64'd0);

        // Random traffic
        for (int c = 0; c < 700; c++) begin
            dv_r = 1'($urandom_range(0, 1));
            pc_r = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) pc_r = 32'(4 * $urandom_range(0, 7));
            pr_r = 1'($urandom_range(0, 1));
            ev_r = ($urandom_range(0, 9) < 4);
            epc_r = 32'(4 * $urandom_range(0, 7));
            eo_r  = 1'($urandom_range(0, 1));
            if (mq.size() > 0) begin
                if ($urandom_range(0, 9) < 8) epc_r = mq[0].pc;
                if ($urandom_range(0, 9) < 8) eo_r  = mq[0].pred;
            end
            fl_r = ($urandom_range(0, 99) < 3);
            drive(dv_r, pc_r, pr_r, ev_r, epc_r, eo_r, fl_r);
            tick();
        end
        idle(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
